// File: rtl/mp_dcache_tag_ctrl.sv
// mp_dcache_tag_ctrl
// Tag-array controller for a direct-mapped data cache. It owns a single-port
// tag SRAM (one entry per set), clears it after reset or on an
// invalidate-all request, and serves lookups and tag updates from the core.
//
// Tag word layout: [TAG_WIDTH+1] valid, [TAG_WIDTH] dirty, [TAG_WIDTH-1:0] tag.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   lkp_*             lookup request (valid/ready, set, tag) and its
//                     one-cycle-later response (valid, hit, dirty, victim tag)
//   upd_*             tag write request (valid/ready, set, tag, valid, dirty)
//   inv_all_req       level-sampled request to clear the whole array
//   busy              high while the array is being cleared (INIT or INV)
//   tag_*0            single-port SRAM command/data interface
module mp_dcache_tag_ctrl #(
    parameter int TAG_WIDTH = 22,
    parameter int SET_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lkp_valid,
    output logic                 lkp_ready,
    input  logic [SET_WIDTH-1:0] lkp_set,
    input  logic [TAG_WIDTH-1:0] lkp_tag,
    output logic                 lkp_resp_valid,
    output logic                 lkp_hit,
    output logic                 lkp_dirty,
    output logic [TAG_WIDTH-1:0] lkp_victim_tag,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [SET_WIDTH-1:0] upd_set,
    input  logic [TAG_WIDTH-1:0] upd_tag,
    input  logic                 upd_vld,
    input  logic                 upd_dirty,
    input  logic                 inv_all_req,
    output logic                 busy,
    output logic                 tag_csb0,
    output logic                 tag_web0,
    output logic [SET_WIDTH-1:0] tag_addr0,
    output logic [TAG_WIDTH+1:0] tag_din0,
    input  logic [TAG_WIDTH+1:0] tag_dout0
);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        INV
    } state_t;

    state_t                 state_q, state_d;
    logic [SET_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   respValid_q, respValid_d;
    logic [TAG_WIDTH-1:0]   lkpTag_q, lkpTag_d;

    logic                   respShown;
    logic                   storedValid;
    logic                   storedDirty;
    logic [TAG_WIDTH-1:0]   storedTag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            respValid_q <= 1'b0;
            lkpTag_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            respValid_q <= respValid_d;
            lkpTag_q    <= lkpTag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        respValid_d = 1'b0;
        lkpTag_d    = lkpTag_q;
        lkp_ready   = 1'b0;
        upd_ready   = 1'b0;
        busy        = 1'b1;
        tag_csb0    = 1'b1;
        tag_web0    = 1'b1;
        tag_addr0   = '0;
        tag_din0    = '0;

        case (state_q)
            INIT, INV: begin
                // Clear sequence: one zero write per cycle, walking every set.
                // inv_all_req is deliberately not looked at here.
                tag_csb0 = 1'b0;
                tag_web0 = 1'b0;
                tag_addr0 = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy      = 1'b0;
                upd_ready = 1'b1;
                // Updates win; holding off lookups keeps the single SRAM port
                // to one command per cycle.
                lkp_ready = !upd_valid;
                if (upd_valid) begin
                    tag_csb0  = 1'b0;
                    tag_web0  = 1'b0;
                    tag_addr0 = upd_set;
                    tag_din0  = {upd_vld, upd_dirty, upd_tag};
                end else if (lkp_valid) begin
                    tag_csb0    = 1'b0;
                    tag_web0    = 1'b1;
                    tag_addr0   = lkp_set;
                    respValid_d = 1'b1;
                    lkpTag_d    = lkp_tag;
                end
                // A request accepted this cycle still completes; its response
                // simply appears during the first INV cycle.
                if (inv_all_req) begin
                    state_d = INV;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase

        // While reset is held, outputs must look idle even before the state
        // register has taken its reset value.
        if (rst) begin
            lkp_ready = 1'b0;
            upd_ready = 1'b0;
            busy      = 1'b1;
            tag_csb0  = 1'b1;
            tag_web0  = 1'b1;
            tag_addr0 = '0;
            tag_din0  = '0;
        end
    end

    // Read data is held by the SRAM until the next enabled command, so it is
    // still valid in the response cycle even if a new command issues then.
    assign respShown      = respValid_q && !rst;
    assign storedValid    = tag_dout0[TAG_WIDTH+1];
    assign storedDirty    = tag_dout0[TAG_WIDTH];
    assign storedTag      = tag_dout0[TAG_WIDTH-1:0];

    assign lkp_resp_valid = respShown;
    assign lkp_hit        = respShown && storedValid && (storedTag == lkpTag_q);
    assign lkp_dirty      = respShown && storedValid && storedDirty;
    assign lkp_victim_tag = respShown ? storedTag : '0;

endmodule

// File: tb/tb_mp_dcache_tag_ctrl.sv
// tb_mp_dcache_tag_ctrl
// Directed bench for mp_dcache_tag_ctrl with a behavioural tag SRAM.
module tb_mp_dcache_tag_ctrl;

    localparam int TW = 22;
    localparam int SW = 4;

    logic          clk;
    logic          rst;
    logic          lkp_valid;
    logic          lkp_ready;
    logic [SW-1:0] lkp_set;
    logic [TW-1:0] lkp_tag;
    logic          lkp_resp_valid;
    logic          lkp_hit;
    logic          lkp_dirty;
    logic [TW-1:0] lkp_victim_tag;
    logic          upd_valid;
    logic          upd_ready;
    logic [SW-1:0] upd_set;
    logic [TW-1:0] upd_tag;
    logic          upd_vld;
    logic          upd_dirty;
    logic          inv_all_req;
    logic          busy;
    logic          tag_csb0;
    logic          tag_web0;
    logic [SW-1:0] tag_addr0;
    logic [TW+1:0] tag_din0;
    logic [TW+1:0] tag_dout0;

    int errors = 0;
    int checks = 0;

    logic [TW+1:0] mem [16];

    mp_dcache_tag_ctrl #(.TAG_WIDTH(TW), .SET_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_set(lkp_set), .lkp_tag(lkp_tag),
        .lkp_resp_valid(lkp_resp_valid), .lkp_hit(lkp_hit), .lkp_dirty(lkp_dirty),
        .lkp_victim_tag(lkp_victim_tag),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_set(upd_set), .upd_tag(upd_tag),
        .upd_vld(upd_vld), .upd_dirty(upd_dirty),
        .inv_all_req(inv_all_req), .busy(busy),
        .tag_csb0(tag_csb0), .tag_web0(tag_web0), .tag_addr0(tag_addr0),
        .tag_din0(tag_din0), .tag_dout0(tag_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: read data appears at the command edge and holds;
    // writes are visible to a command at the following edge.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '1;
        tag_dout0 = '0;
    end

    always @(posedge clk) begin
        if (!tag_csb0) begin
            if (!tag_web0) mem[tag_addr0] <= tag_din0;
            else           tag_dout0 <= mem[tag_addr0];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lv, input logic [SW-1:0] ls, input logic [TW-1:0] lt,
                                 input logic uv, input logic [SW-1:0] us, input logic [TW-1:0] ut,
                                 input logic uvl, input logic ud, input logic inv);
        lkp_valid = lv; lkp_set = ls; lkp_tag = lt;
        upd_valid = uv; upd_set = us; upd_tag = ut; upd_vld = uvl; upd_dirty = ud;
        inv_all_req = inv;
        #1;
    endtask

    task automatic checkIdleResp(input string name);
        checkOutput({name, "_rv"}, 32'(lkp_resp_valid), 32'd0);
        checkOutput({name, "_hit"}, 32'(lkp_hit), 32'd0);
        checkOutput({name, "_vic"}, 32'(lkp_victim_tag), 32'd0);
    endtask

    // Walk a full 16-cycle clear sequence, starting in its first cycle.
    task automatic checkClear(input string name, input int invAt);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, (k == invAt) ? 1'b1 : 1'b0);
            checkOutput({name, "_busy"}, 32'(busy), 32'd1);
            checkOutput({name, "_csb"}, 32'(tag_csb0), 32'd0);
            checkOutput({name, "_web"}, 32'(tag_web0), 32'd0);
            checkOutput({name, "_addr"}, 32'(tag_addr0), 32'(k));
            checkOutput({name, "_din"}, 32'(tag_din0), 32'd0);
            checkOutput({name, "_lrdy"}, 32'(lkp_ready), 32'd0);
            checkOutput({name, "_urdy"}, 32'(upd_ready), 32'd0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput({name, "_done_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_done_lrdy"}, 32'(lkp_ready), 32'd1);
        checkOutput({name, "_done_urdy"}, 32'(upd_ready), 32'd1);
        checkOutput({name, "_idle_csb"}, 32'(tag_csb0), 32'd1);
        checkOutput({name, "_idle_addr"}, 32'(tag_addr0), 32'd0);
    endtask

    logic [TW-1:0] expVic [8];
    logic          expHit [8];

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        // Held in reset
        checkOutput("rst_busy", 32'(busy), 32'd1);
        checkOutput("rst_lrdy", 32'(lkp_ready), 32'd0);
        checkOutput("rst_urdy", 32'(upd_ready), 32'd0);
        checkOutput("rst_csb", 32'(tag_csb0), 32'd1);
        checkOutput("rst_web", 32'(tag_web0), 32'd1);
        checkOutput("rst_addr", 32'(tag_addr0), 32'd0);
        checkOutput("rst_din", 32'(tag_din0), 32'd0);
        checkIdleResp("rst");

        // Initial clear
        rst = 1'b0;
        checkClear("init", -1);

        // Update set 3, then look it up the very next cycle
        applyStimulus(0, 0, 0, 1, 4'd3, 22'h12345, 1, 0, 0);
        checkOutput("upd_lrdy", 32'(lkp_ready), 32'd0);
        checkOutput("upd_csb", 32'(tag_csb0), 32'd0);
        checkOutput("upd_web", 32'(tag_web0), 32'd0);
        checkOutput("upd_addr", 32'(tag_addr0), 32'd3);
        checkOutput("upd_din", 32'(tag_din0), 32'h0081_2345);
        tick();
        applyStimulus(1, 4'd3, 22'h12345, 0, 0, 0, 0, 0, 0);
        checkOutput("lkp_rdy", 32'(lkp_ready), 32'd1);
        checkOutput("lkp_csb", 32'(tag_csb0), 32'd0);
        checkOutput("lkp_web", 32'(tag_web0), 32'd1);
        checkOutput("lkp_addr", 32'(tag_addr0), 32'd3);
        checkIdleResp("lkp_pre");
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hit1_rv", 32'(lkp_resp_valid), 32'd1);
        checkOutput("hit1_hit", 32'(lkp_hit), 32'd1);
        checkOutput("hit1_dirty", 32'(lkp_dirty), 32'd0);
        checkOutput("hit1_vic", 32'(lkp_victim_tag), 32'h12345);
        tick();
        checkIdleResp("hit1_after");

        // Miss on set 3
        applyStimulus(1, 4'd3, 22'h00001, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("miss_rv", 32'(lkp_resp_valid), 32'd1);
        checkOutput("miss_hit", 32'(lkp_hit), 32'd0);
        checkOutput("miss_dirty", 32'(lkp_dirty), 32'd0);
        checkOutput("miss_vic", 32'(lkp_victim_tag), 32'h12345);
        tick();

        // Mark set 3 dirty, look it up again
        applyStimulus(0, 0, 0, 1, 4'd3, 22'h12345, 1, 1, 0);
        tick();
        applyStimulus(1, 4'd3, 22'h12345, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("dirty_hit", 32'(lkp_hit), 32'd1);
        checkOutput("dirty_dirty", 32'(lkp_dirty), 32'd1);
        tick();

        // Update and lookup requested together: update goes first
        applyStimulus(1, 4'd5, 22'h00ABC, 1, 4'd5, 22'h00ABC, 1, 0, 0);
        checkOutput("prio_lrdy", 32'(lkp_ready), 32'd0);
        checkOutput("prio_urdy", 32'(upd_ready), 32'd1);
        checkOutput("prio_web", 32'(tag_web0), 32'd0);
        checkOutput("prio_addr", 32'(tag_addr0), 32'd5);
        tick();
        applyStimulus(1, 4'd5, 22'h00ABC, 0, 0, 0, 0, 0, 0);
        checkOutput("prio2_lrdy", 32'(lkp_ready), 32'd1);
        checkOutput("prio2_web", 32'(tag_web0), 32'd1);
        checkOutput("prio2_rv", 32'(lkp_resp_valid), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("prio_resp_hit", 32'(lkp_hit), 32'd1);
        checkOutput("prio_resp_vic", 32'(lkp_victim_tag), 32'h00ABC);
        tick();

        // Eight back-to-back lookups on sets 0..7
        for (int i = 0; i < 8; i++) begin
            expHit[i] = 1'b0;
            expVic[i] = '0;
        end
        expHit[3] = 1'b1; expVic[3] = 22'h12345;
        expHit[5] = 1'b1; expVic[5] = 22'h00ABC;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) applyStimulus(1, SW'(i), expVic[i], 0, 0, 0, 0, 0, 0);
            else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (i < 8) checkOutput("stream_lrdy", 32'(lkp_ready), 32'd1);
            if (i > 0) begin
                checkOutput("stream_rv", 32'(lkp_resp_valid), 32'd1);
                checkOutput("stream_hit", 32'(lkp_hit), 32'(expHit[i-1]));
                checkOutput("stream_vic", 32'(lkp_victim_tag), 32'(expVic[i-1]));
            end else begin
                checkOutput("stream_rv0", 32'(lkp_resp_valid), 32'd0);
            end
            tick();
        end
        checkIdleResp("stream_end");

        // Invalidate-all together with an accepted lookup
        applyStimulus(1, 4'd3, 22'h12345, 0, 0, 0, 0, 0, 1);
        checkOutput("inv_lrdy", 32'(lkp_ready), 32'd1);
        checkOutput("inv_busy0", 32'(busy), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("inv_resp_rv", 32'(lkp_resp_valid), 32'd1);
        checkOutput("inv_resp_hit", 32'(lkp_hit), 32'd1);
        checkOutput("inv_resp_dirty", 32'(lkp_dirty), 32'd1);
        checkClear("inv", -1);
        applyStimulus(1, 4'd3, 22'h12345, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("postinv_rv", 32'(lkp_resp_valid), 32'd1);
        checkOutput("postinv_hit", 32'(lkp_hit), 32'd0);
        checkOutput("postinv_dirty", 32'(lkp_dirty), 32'd0);
        checkOutput("postinv_vic", 32'(lkp_victim_tag), 32'd0);
        tick();

        // Reset in the middle of an invalidate, then inv_all_req during INIT
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) tick();
        checkOutput("midinv_addr", 32'(tag_addr0), 32'd7);
        checkOutput("midinv_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_csb", 32'(tag_csb0), 32'd1);
        checkOutput("midrst_addr", 32'(tag_addr0), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b0;
        checkClear("reinit", 5);
        tick();
        checkOutput("reinit_stay_busy", 32'(busy), 32'd0);

        // Reset with a lookup response pending
        applyStimulus(1, 4'd1, 22'h0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checkIdleResp("pendrst");
        checkOutput("pendrst_lrdy", 32'(lkp_ready), 32'd0);
        tick();
        rst = 1'b0;
        checkClear("pendinit", -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mp_dcache_tag_ctrl.md
MP_DCACHE_TAG_CTRL -- requirements
Module: mp_dcache_tag_ctrl

Interface
REQ-001 Parameters SHALL be: TAG_WIDTH, default 22, stored tag bits; SET_WIDTH, default 4, set index bits (16 sets); tag word width is TAG_WIDTH+2.
REQ-002 The design SHALL use one clock and a synchronous, active-high reset. Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- lkp_valid  in  1  lookup request
- lkp_ready  out  1  lookup accepted when valid&&ready
- lkp_set  in  SET_WIDTH  lookup set
- lkp_tag  in  TAG_WIDTH  lookup tag
- lkp_resp_valid  out  1  lookup result valid
- lkp_hit  out  1  hit result
- lkp_dirty  out  1  stored line valid and dirty
- lkp_victim_tag  out  TAG_WIDTH  stored tag of set
- upd_valid  in  1  tag write request
- upd_ready  out  1  write accepted when valid&&ready
- upd_set  in  SET_WIDTH  write set
- upd_tag  in  TAG_WIDTH  tag to store
- upd_vld  in  1  valid bit to store
- upd_dirty  in  1  dirty bit to store
- inv_all_req  in  1  invalidate-all request, level-sampled
- busy  out  1  INIT or INV sequence running
- tag_csb0  out  1  SRAM chip select, active low
- tag_web0  out  1  SRAM write enable, active low
- tag_addr0  out  SET_WIDTH  SRAM address
- tag_din0  out  TAG_WIDTH+2  SRAM write data
- tag_dout0  in  TAG_WIDTH+2  SRAM read data

Function
REQ-003 The tag word format SHALL be: [TAG_WIDTH+1] valid, [TAG_WIDTH] dirty, [TAG_WIDTH-1:0] tag.
REQ-004 SRAM timing SHALL be: command sampled at edge N; read data on tag_dout0 valid from edge N until the next enabled command; a write lands in memory at edge N+1.
REQ-005 The FSM SHALL have states INIT, RUN and INV.
REQ-006 INIT and INV SHALL each issue 16 back-to-back writes of all-zero words to sets 0..15, using a 4-bit counter incremented once per cycle.
REQ-007 After the write to set 15 is issued, the counter SHALL wrap to 0 and the state SHALL move to RUN the next cycle; each sequence is exactly 16 cycles.
REQ-008 busy SHALL be 1 exactly in INIT and INV.
REQ-009 lkp_ready and upd_ready SHALL be 0 in INIT and INV.
REQ-010 In RUN: upd_ready = 1; lkp_ready = !upd_valid, so updates have fixed priority and at most one SRAM command is issued per cycle.
REQ-011 On an accepted update, the controller SHALL drive tag_csb0=0, tag_web0=0, tag_addr0=upd_set and tag_din0={upd_vld, upd_dirty, upd_tag} in the same cycle.
REQ-012 On an accepted lookup, the controller SHALL drive tag_csb0=0, tag_web0=1, tag_addr0=lkp_set, and register lkp_tag.
REQ-013 In the cycle following an accepted lookup, lkp_resp_valid SHALL be 1 for exactly one cycle (latency 1), with:
- lkp_hit = valid && (stored tag == registered tag)
- lkp_dirty = valid && dirty
- lkp_victim_tag = stored tag
REQ-014 When lkp_resp_valid=0, lkp_hit, lkp_dirty and lkp_victim_tag SHALL be 0.
REQ-015 When no command is issued, tag_csb0 SHALL be 1, tag_web0 1, tag_addr0 0 and tag_din0 0.
REQ-016 Back-to-back operations SHALL behave as follows:
- A lookup accepted the cycle after an update to the same set returns the updated word; no bypass is needed.
- Lookups SHALL sustain one per cycle.
REQ-017 inv_all_req in RUN SHALL cause INV to start the next cycle. Any request accepted in that same cycle still executes, and its lookup response is still delivered in the first INV cycle.
REQ-018 inv_all_req in INIT or INV SHALL be ignored and SHALL NOT restart the sequence.
REQ-019 Handshake: a request SHALL be considered accepted only on valid&&ready at a clock edge; requesters may hold valid across cycles with ready low.

Reset
REQ-020 While rst=1, the block SHALL force: state INIT, counter 0, lkp_resp_valid 0, lkp_ready 0, upd_ready 0, busy 1, tag_csb0 1, tag_web0 1, tag_addr0 0, tag_din0 0.
REQ-021 The first write to set 0 SHALL be issued in the first cycle after rst deasserts.
REQ-022 rst asserted mid-INV, or with a lookup response pending, SHALL discard all pending work and restart INIT from set 0.

Verification
REQ-023 Release reset -> 16 cycles with busy=1 and writes of 0 to addr 0..15 in order -> busy=0 and lkp_ready=1 on cycle 17.
REQ-024 Update set 3 {vld=1, dirty=0, tag=0x12345}, then lookup set 3 tag 0x12345 the next cycle -> lkp_resp_valid=1, lkp_hit=1, lkp_dirty=0 one cycle after lookup acceptance.
REQ-025 Same state, lookup set 3 tag 0x00001 -> lkp_hit=0, lkp_victim_tag=0x12345; then update set 3 dirty=1 and repeat -> lkp_dirty=1.
REQ-026 upd_valid and lkp_valid both held high -> update issued first, lkp_ready=0 that cycle, lookup accepted once upd_valid drops; 8 consecutive lookups -> 8 consecutive one-cycle responses.
REQ-027 In RUN, pulse inv_all_req together with an accepted lookup -> response delivered in the first INV cycle, 16 zero writes follow, then a lookup of any set returns lkp_hit=0.
REQ-028 Assert rst at INV count 7 -> INIT restarts at set 0 with a full 16 cycles; inv_all_req during INIT -> no extension of busy.
